// File: rtl/led_pkg.sv
// led_pkg: mode encodings, direction type and the
// initial-pattern helper shared by the LED sequencer.
package led_pkg;

  localparam int LED_MAX = 64;

  typedef enum logic [1:0] {
    LED_MODE_CHASE_UP = 2'd0,
    LED_MODE_CHASE_DN = 2'd1,
    LED_MODE_PINGPONG = 2'd2,
    LED_MODE_FILL     = 2'd3
  } led_mode_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } led_dir_t;

  // Pattern a mode starts from; caller truncates to LED_NUM.
  function automatic logic [LED_MAX-1:0] led_init_pat(
    input led_mode_t   mode,
    input int unsigned num
  );
    logic [LED_MAX-1:0] one;
    one = LED_MAX'(1);
    unique case (mode)
      LED_MODE_CHASE_DN: led_init_pat = one << (num - 1);
      LED_MODE_FILL:     led_init_pat = '0;
      default:           led_init_pat = one;
    endcase
  endfunction

endpackage

// File: rtl/led_pwm.sv
// led_pwm: free-running PWM counter and duty compare.
// Ports: clk, rst_n, en (hold/clear), duty, on.
// Macro LED_BREATH_EN adds a triangular breathing ramp
// that caps the duty at the current breathing level.
module led_pwm
  import led_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int BREATH_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PWM_BITS-1:0] duty,
  output logic                on
);

  localparam logic [PWM_BITS-1:0] FULL = '1;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_eff;

  if (BREATH_CYC < 1) begin : g_bad_breath
    $error("led_pwm: BREATH_CYC must be >= 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pwm_cnt <= '0;
    else if (!en)
      pwm_cnt <= '0;
    else
      pwm_cnt <= pwm_cnt + 1'b1;
  end

`ifdef LED_BREATH_EN
  localparam int BW =
    (BREATH_CYC > 1) ? $clog2(BREATH_CYC) : 1;
  localparam logic [BW-1:0] BR_MAX = BW'(BREATH_CYC - 1);

  logic [BW-1:0]       br_cnt;
  logic [PWM_BITS-1:0] level;
  logic                br_dn;

  // Level bounces 0..FULL..0 without dwelling on the ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt <= '0;
      level  <= '0;
      br_dn  <= 1'b0;
    end else if (!en) begin
      br_cnt <= '0;
      level  <= '0;
      br_dn  <= 1'b0;
    end else if (br_cnt == BR_MAX) begin
      br_cnt <= '0;
      if (!br_dn) begin
        if (level == FULL) begin
          level <= level - 1'b1;
          br_dn <= 1'b1;
        end else begin
          level <= level + 1'b1;
        end
      end else begin
        if (level == '0) begin
          level <= level + 1'b1;
          br_dn <= 1'b0;
        end else begin
          level <= level - 1'b1;
        end
      end
    end else begin
      br_cnt <= br_cnt + 1'b1;
    end
  end

  assign duty_eff = (level < duty) ? level : duty;
`else
  assign duty_eff = duty;
`endif

  assign on = (duty_eff == FULL) | (pwm_cnt < duty_eff);

endmodule

// File: rtl/led_seq_pwm.sv
// led_seq_pwm: multi-mode LED sequencer with PWM brightness.
// Ports: clk, rst_n, en_i, mode_i, duty_i -> step_o, led_o.
// Macro LED_BREATH_EN enables breathing inside led_pwm.
module led_seq_pwm
  import led_pkg::*;
#(
  parameter int   LED_NUM     = 8,
  parameter logic LED_ON_MODE = 1'b0,
  parameter int   CLK_FREQ    = 50_000_000,
  parameter int   STEP_US     = 100_000,
  parameter int   PWM_BITS    = 8,
  parameter int   BREATH_CYC  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [1:0]          mode_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                step_o,
  output logic [LED_NUM-1:0]  led_o
);

  localparam int STEP_CYC = CLK_FREQ / 1_000_000 * STEP_US;
  localparam int TW =
    (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(STEP_CYC - 1);
  localparam logic [LED_NUM-1:0] BIT0 = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] LED_OFF =
    {LED_NUM{~LED_ON_MODE}};

  if (STEP_CYC < 2) begin : g_bad_step
    $error("led_seq_pwm: STEP_CYC must be >= 2");
  end
  if (LED_NUM < 1 || LED_NUM > LED_MAX) begin : g_bad_num
    $error("led_seq_pwm: LED_NUM out of range");
  end

  logic [TW-1:0]      tick, tick_nxt;
  led_mode_t          mode_q, mode_nxt, mode_in;
  led_dir_t           dir, dir_nxt, dir_adv;
  logic [LED_NUM-1:0] pat, pat_nxt, pat_adv, pat_init;
  logic [LED_NUM-1:0] lit;
  logic               step_nxt;
  logic               on;

  assign mode_in  = led_mode_t'(mode_i);
  assign pat_init = LED_NUM'(led_init_pat(mode_in, LED_NUM));

  led_pwm #(
    .PWM_BITS   (PWM_BITS),
    .BREATH_CYC (BREATH_CYC)
  ) u_pwm (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_i),
    .duty  (duty_i),
    .on    (on)
  );

  // One step of the current mode's pattern.
  always_comb begin
    pat_adv = pat;
    dir_adv = dir;
    unique case (mode_q)
      LED_MODE_CHASE_UP:
        pat_adv = (pat << 1) | (pat >> (LED_NUM - 1));
      LED_MODE_CHASE_DN:
        pat_adv = (pat >> 1) | (pat << (LED_NUM - 1));
      LED_MODE_PINGPONG: begin
        // Turn around on an end so it is not shown twice.
        if (LED_NUM > 1) begin
          if (dir == DIR_UP) begin
            if (pat[LED_NUM-1]) begin
              pat_adv = pat >> 1;
              dir_adv = DIR_DN;
            end else begin
              pat_adv = pat << 1;
            end
          end else begin
            if (pat[0]) begin
              pat_adv = pat << 1;
              dir_adv = DIR_UP;
            end else begin
              pat_adv = pat >> 1;
            end
          end
        end
      end
      LED_MODE_FILL:
        pat_adv = (&pat) ? '0 : ((pat << 1) | BIT0);
    endcase
  end

  always_comb begin
    tick_nxt = tick;
    mode_nxt = mode_q;
    pat_nxt  = pat;
    dir_nxt  = dir;
    step_nxt = 1'b0;
    if (!en_i) begin
      tick_nxt = '0;
      mode_nxt = mode_in;
      pat_nxt  = pat_init;
      dir_nxt  = DIR_UP;
    end else if (tick == TICK_MAX) begin
      tick_nxt = '0;
      step_nxt = 1'b1;
      // A pending mode change consumes this step.
      if (mode_in != mode_q) begin
        mode_nxt = mode_in;
        pat_nxt  = pat_init;
        dir_nxt  = DIR_UP;
      end else begin
        pat_nxt = pat_adv;
        dir_nxt = dir_adv;
      end
    end else begin
      tick_nxt = tick + 1'b1;
    end
  end

  assign lit = pat & {LED_NUM{on}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick   <= '0;
      mode_q <= LED_MODE_CHASE_UP;
      pat    <= BIT0;
      dir    <= DIR_UP;
      step_o <= 1'b0;
      led_o  <= LED_OFF;
    end else begin
      tick   <= tick_nxt;
      mode_q <= mode_nxt;
      pat    <= pat_nxt;
      dir    <= dir_nxt;
      step_o <= step_nxt;
      if (!en_i)
        led_o <= LED_OFF;
      else
        led_o <= LED_ON_MODE ? lit : ~lit;
    end
  end

endmodule

// File: tb/tb_led_seq_pwm.sv
// tb_led_seq_pwm: four sequencer configurations checked
// every cycle against a step-index reference model.
module tb_led_seq_pwm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] duty = 8'hFF;

  logic [4:0] led_a;
  logic [3:0] led_b;
  logic [2:0] led_c;
  logic [0:0] led_d;
  logic       step_a, step_b, step_c, step_d;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_seq_pwm #(.LED_NUM(5), .LED_ON_MODE(1'b0),
    .CLK_FREQ(1_000_000), .STEP_US(4)) u_a (
    .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode),
    .duty_i(duty), .step_o(step_a), .led_o(led_a));
  led_seq_pwm #(.LED_NUM(4), .LED_ON_MODE(1'b1),
    .CLK_FREQ(1_000_000), .STEP_US(3)) u_b (
    .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode),
    .duty_i(duty), .step_o(step_b), .led_o(led_b));
  led_seq_pwm #(.LED_NUM(3), .LED_ON_MODE(1'b1),
    .CLK_FREQ(1_000_000), .STEP_US(2)) u_c (
    .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode),
    .duty_i(duty), .step_o(step_c), .led_o(led_c));
  led_seq_pwm #(.LED_NUM(1), .LED_ON_MODE(1'b0),
    .CLK_FREQ(1_000_000), .STEP_US(2)) u_d (
    .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode),
    .duty_i(duty), .step_o(step_d), .led_o(led_d));

  int nn[4]  = '{5, 4, 3, 1};
  int lon[4] = '{0, 1, 1, 0};
  int sc[4]  = '{4, 3, 2, 2};

  int m_cnt[4], m_k[4], m_mq[4], m_pwm[4];
  int e_led[4], e_step[4];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // k-th pattern of a mode, straight from the mode's rule.
  function automatic int pat_of(int md, int k, int n);
    int p;
    case (md)
      0: return 1 << (k % n);
      1: return 1 << (n - 1 - (k % n));
      2: begin
        if (n == 1) return 1;
        p = k % (2 * (n - 1));
        return 1 << ((p < n) ? p : 2 * (n - 1) - p);
      end
      default: return (1 << (k % (n + 1))) - 1;
    endcase
  endfunction

  function automatic int off_of(int i);
    return (lon[i] != 0) ? 0 : (1 << nn[i]) - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_k[i] = 0; m_mq[i] = 0; m_pwm[i] = 0;
      e_led[i] = off_of(i); e_step[i] = 0;
    end
  endtask

  task automatic model_step();
    int lit;
    bit on;
    for (int i = 0; i < 4; i++) begin
      if (!en) begin
        m_cnt[i] = 0; m_pwm[i] = 0; m_k[i] = 0;
        m_mq[i] = int'(mode);
        e_step[i] = 0; e_led[i] = off_of(i);
      end else begin
        on = (duty == 8'hFF) || (m_pwm[i] < int'(duty));
        lit = on ? pat_of(m_mq[i], m_k[i], nn[i]) : 0;
        e_led[i] = (lon[i] != 0) ? lit
                 : (~lit & ((1 << nn[i]) - 1));
        m_pwm[i] = (m_pwm[i] + 1) % 256;
        m_cnt[i]++;
        e_step[i] = 0;
        if (m_cnt[i] == sc[i]) begin
          m_cnt[i] = 0;
          e_step[i] = 1;
          if (int'(mode) != m_mq[i]) begin
            m_mq[i] = int'(mode);
            m_k[i] = 0;
          end else begin
            m_k[i]++;
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] led_of(int i);
    case (i)
      0: return 32'(led_a);
      1: return 32'(led_b);
      2: return 32'(led_c);
      default: return 32'(led_d);
    endcase
  endfunction

  function automatic logic [31:0] step_of(int i);
    case (i)
      0: return 32'(step_a);
      1: return 32'(step_b);
      2: return 32'(step_c);
      default: return 32'(step_d);
    endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("led%0d", i), led_of(i), e_led[i]);
      chk($sformatf("step%0d", i), step_of(i), e_step[i]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    check_all();
  endtask

  // Cycles until step_a, bounded at 20.
  task automatic wait_step_a(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!step_a && n < 20);
  endtask

  int n, cnt;

  initial begin
    model_reset();
    repeat (3) cycle();
    chk("rst_led_a", 32'(led_a), 32'h1F);
    chk("rst_step_a", 32'(step_a), 32'h0);
    chk("rst_led_b", 32'(led_b), 32'h0);
    rst_n = 1'b1;
    repeat (3) cycle();
    chk("en0_led_a", 32'(led_a), 32'h1F);

    en = 1'b1; mode = 2'd0; duty = 8'hFF;
    repeat (24) cycle();
    mode = 2'd2;
    repeat (40) cycle();
    mode = 2'd3;
    repeat (30) cycle();

    // mode change two cycles into a step of A
    wait_step_a(n);
    chk("sync_a", 32'(step_a), 32'h1);
    repeat (2) cycle();
    mode = 2'd1;
    wait_step_a(n);
    chk("mchg_lat", 32'(n), 32'd2);
    cycle();
    chk("mchg_pat", 32'(led_a), 32'h0F);

    // PWM duty windows over 256 cycles
    mode = 2'd0;
    duty = 8'd64;
    cycle();
    cnt = 0;
    for (int t = 0; t < 256; t++) begin
      cycle();
      if (led_a != 5'h1F) cnt++;
    end
    chk("pwm64", 32'(cnt), 32'd64);
    duty = 8'd0;
    cycle();
    cnt = 0;
    for (int t = 0; t < 256; t++) begin
      cycle();
      if (led_a != 5'h1F) cnt++;
    end
    chk("pwm0", 32'(cnt), 32'd0);
    duty = 8'hFF;
    cycle();
    cnt = 0;
    for (int t = 0; t < 256; t++) begin
      cycle();
      if (led_a != 5'h1F) cnt++;
    end
    chk("pwm255", 32'(cnt), 32'd256);

    // enable drop mid-step, then re-enable
    wait_step_a(n);
    repeat (2) cycle();
    en = 1'b0;
    cycle();
    chk("endrop_led", 32'(led_a), 32'h1F);
    cycle();
    en = 1'b1;
    wait_step_a(n);
    chk("reen_lat", 32'(n), 32'd4);

    // async reset with no clock edge
    repeat (2) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led_a", 32'(led_a), 32'h1F);
    chk("arst_step_a", 32'(step_a), 32'h0);
    chk("arst_led_c", 32'(led_c), 32'h0);
    model_reset();
    cycle();
    rst_n = 1'b1;

    for (int t = 0; t < 3000; t++) begin
      if (!en) en = ($urandom_range(0, 3) == 0);
      else en = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 11) == 0)
        mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: duty = 8'h00;
          1: duty = 8'hFF;
          default: duty = 8'($urandom_range(0, 255));
        endcase
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
